hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It sits upstream of the EX-stage forwarding logic and generates the load/flush enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles:
- instruction-memory wait stalls;
- data-memory wait stalls;
- branch/jump redirects resolved in EX, including a redirect that arrives while an instruction fetch is still outstanding.

Because EX-stage forwarding takes load data directly from the data-memory response, no load-use bubble is generated here.

## Interface
- (no parameters)
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_read  in  1  fetch request outstanding this cycle
- imem_resp  in  1  fetch data valid this cycle
- dmem_req  in  1  EX/MEM holds a load or store (read or write asserted)
- dmem_resp  in  1  data access completes this cycle
- br_en  in  1  EX resolved a taken branch/jal/jalr (misprediction vs. PC+4)
- br_target  in  32  redirect address from EX
- load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1 each  register load enables
- flush_ifid, flush_idex  out  1 each  load a NOP bubble (regfile_ld=0, opcode=NOP) instead of data
- pc_redirect  out  1  PC mux selects pc_redirect_addr
- pc_redirect_addr  out  32  redirect target (br_target, or the latched target)
- stall_cycles, flush_count  out  32 each  performance counters (see Configuration)

## Operation
- State: FSM {RUN, REDIR_WAIT}, plus the 32-bit register tgt_q.
- Priority 1, D-stall: dmem_req && !dmem_resp.
  - All load_* = 0; all flush = 0; pc_redirect = 0.
  - br_en is ignored, since EX is frozen and will re-present it.
- Priority 2, RUN with br_en, when imem is idle or imem_resp=1:
  - pc_redirect = 1, pc_redirect_addr = br_target, load_pc = 1.
  - flush_ifid = flush_idex = 1.
  - load_idex, load_exmem and load_memwb = 1.
- Priority 2', RUN with br_en while imem_read && !imem_resp:
  - The fetch cannot be aborted. Latch tgt_q ← br_target and go to REDIR_WAIT.
  - flush_idex = 1; load_idex, load_exmem and load_memwb = 1; load_pc = load_ifid = 0.
- REDIR_WAIT:
  - pc_redirect_addr = tgt_q.
  - Until imem_resp: load_pc = load_ifid = 0; flush_idex = 1; downstream advances unless D-stalled.
  - On imem_resp: pc_redirect = 1; load_pc = 1; flush_ifid = 1, which discards the fetched word; return to RUN.
  - br_en is ignored in REDIR_WAIT, because every younger instruction is already a bubble.
- Priority 3, I-stall in RUN: imem_read && !imem_resp.
  - load_pc = load_ifid = 0; flush_idex = 1; load_idex, load_exmem and load_memwb = 1.
- Otherwise: all load_* = 1; all flush = 0; pc_redirect = 0.
- A D-stall has precedence over REDIR_WAIT: state and tgt_q are held. If imem_resp arrives during a D-stall, the redirect is deferred until the D-stall clears; the fetch unit holds its response until load_ifid.

## Timing
- All outputs are combinational from the inputs and the registered state. State, tgt_q and the counters update on posedge clk.
- Redirect latency:
  - with the fetch idle, PC = target on the edge after br_en;
  - in REDIR_WAIT, PC = target on the edge that consumes imem_resp.
- Reset (rst_n=0, asynchronous):
  - state = RUN, tgt_q = 0, counters = 0;
  - outputs during reset: all load_* = 0, flush = 0, pc_redirect = 0.
  - Deasserting reset in the middle of a fetch re-enters RUN. Any stale imem_resp is treated as a normal fetch.
- Simultaneous br_en and imem_resp in RUN: immediate redirect (Priority 2); no REDIR_WAIT.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle where load_pc=0 outside reset;
  - flush_count increments on every cycle with flush_ifid=1;
  - both counters saturate at 0xFFFF_FFFF.
- Undefined: no counter registers; both outputs are tied to 0.

## Test plan
- Reset mid-run: rst_n low with dmem_req=1 → all load_*=0 immediately. After release with no stalls, all load_*=1 and counters=0.
- D-stall: dmem_req=1, dmem_resp low for 3 cycles → 3 cycles with all load_*=0. Cycle 4 with resp=1: all load_*=1, and stall_cycles=3 when the counters are enabled.
- Branch with the fetch idle: br_en=1, br_target=0x0000_0060 → same cycle: pc_redirect=1, pc_redirect_addr=0x60, flush_ifid=flush_idex=1. The next PC is 0x60.
- Branch during a fetch: imem_read=1, imem_resp=0, br_en=1, target 0x80 → REDIR_WAIT. 2 further wait cycles: load_pc=0 and flush_idex=1. On imem_resp: pc_redirect=1, addr=0x80, flush_ifid=1; then RUN.
- REDIR_WAIT overlapped by a D-stall: imem_resp and a D-stall in the same cycle → no redirect and all loads 0. The next cycle, once the D-stall has cleared and imem_resp is held, the redirect to tgt_q fires.
- Counter saturation (HAZARD_PERF_CNT_EN): force stall_cycles to 0xFFFF_FFFE, then apply 3 stall cycles → the counter holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage RV32I core.
//
// Produces the load/flush enables for the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It covers imem wait stalls, dmem wait stalls and EX-resolved
// redirects. A redirect that arrives while a fetch is outstanding is parked in
// REDIR_WAIT until the fetch completes.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall_cycles / flush_count performance counters. Without it, both outputs
// are tied to 0.
//
// State table:
//   state      | meaning
//   RUN        | normal operation, redirects taken immediately when fetch idle/done
//   REDIR_WAIT | redirect latched in tgt_q, waiting for the in-flight fetch to return
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_read, imem_resp           fetch outstanding / fetch data valid
//   dmem_req, dmem_resp            data access pending / data access completes
//   br_en, br_target               EX redirect request and target
//   load_pc .. load_memwb          register load enables
//   flush_ifid, flush_idex         load a NOP bubble instead of data
//   pc_redirect, pc_redirect_addr  PC mux select and redirect target
//   stall_cycles, flush_count      performance counters
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        br_en,
    input  logic [31:0] br_target,
    output logic        load_pc,
    output logic        load_ifid,
    output logic        load_idex,
    output logic        load_exmem,
    output logic        load_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_addr,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {RUN = 1'b0, REDIR_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        d_stall, i_busy;

    assign d_stall = dmem_req && !dmem_resp;
    assign i_busy  = imem_read && !imem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        load_pc          = 1'b1;
        load_ifid        = 1'b1;
        load_idex        = 1'b1;
        load_exmem       = 1'b1;
        load_memwb       = 1'b1;
        flush_ifid       = 1'b0;
        flush_idex       = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = (state_q == REDIR_WAIT) ? tgt_q : br_target;

        if (!rst_n || d_stall) begin
            // Whole pipe frozen; EX will re-present any br_en, and a pending
            // REDIR_WAIT resumes once the data access completes.
            load_pc    = 1'b0;
            load_ifid  = 1'b0;
            load_idex  = 1'b0;
            load_exmem = 1'b0;
            load_memwb = 1'b0;
        end else if (state_q == REDIR_WAIT) begin
            flush_idex = 1'b1;
            if (imem_resp) begin
                // Fetched word is wrong-path: it is discarded into IF/ID as a
                // bubble, and ID/EX stays a bubble so the stale IF/ID content
                // never advances.
                pc_redirect = 1'b1;
                flush_ifid  = 1'b1;
                state_d     = RUN;
            end else begin
                load_pc   = 1'b0;
                load_ifid = 1'b0;
            end
        end else if (br_en && !i_busy) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = br_target;
            flush_ifid       = 1'b1;
            flush_idex       = 1'b1;
        end else if (br_en) begin
            // Fetch cannot be aborted; park the target until it returns.
            tgt_d      = br_target;
            state_d    = REDIR_WAIT;
            load_pc    = 1'b0;
            load_ifid  = 1'b0;
            flush_idex = 1'b1;
        end else if (i_busy) begin
            load_pc    = 1'b0;
            load_ifid  = 1'b0;
            flush_idex = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!load_pc && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if (flush_ifid && flush_q != 32'hFFFF_FFFF)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read, imem_resp, dmem_req, dmem_resp, br_en;
    logic [31:0] br_target;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        flush_ifid, flush_idex, pc_redirect;
    logic [31:0] pc_redirect_addr, stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_read        (imem_read),
        .imem_resp        (imem_resp),
        .dmem_req         (dmem_req),
        .dmem_resp        (dmem_resp),
        .br_en            (br_en),
        .br_target        (br_target),
        .load_pc          (load_pc),
        .load_ifid        (load_ifid),
        .load_idex        (load_idex),
        .load_exmem       (load_exmem),
        .load_memwb       (load_memwb),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    // {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, pc_redirect}
    logic [7:0] ctl;
    assign ctl = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                  flush_ifid, flush_idex, pc_redirect};

    typedef struct {
        logic        ir, irsp, dreq, drsp, br;
        logic [31:0] tgt;
        logic [7:0]  exp_ctl;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic irsp, input logic dreq,
                         input logic drsp, input logic br, input logic [31:0] tgt);
        imem_read = ir; imem_resp = irsp; dmem_req = dreq;
        dmem_resp = drsp; br_en = br; br_target = tgt;
    endtask

    initial begin
        int exp_stall, exp_flush;
        //            ir irsp dreq drsp br  tgt            ctl           addr
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0000_0000, 8'b11111_000, 32'h0000_0000}; // idle
        vecs[1]  = '{0, 0, 1, 0, 1, 32'h0000_0044, 8'b00000_000, 32'h0000_0044}; // D-stall, br ignored
        vecs[2]  = '{0, 0, 1, 0, 0, 32'h0000_0000, 8'b00000_000, 32'h0000_0000};
        vecs[3]  = '{0, 0, 1, 0, 0, 32'h0000_0000, 8'b00000_000, 32'h0000_0000};
        vecs[4]  = '{0, 0, 1, 1, 0, 32'h0000_0000, 8'b11111_000, 32'h0000_0000}; // D done
        vecs[5]  = '{0, 0, 0, 0, 1, 32'h0000_0060, 8'b11111_111, 32'h0000_0060}; // branch, fetch idle
        vecs[6]  = '{1, 0, 0, 0, 0, 32'h0000_0000, 8'b00111_010, 32'h0000_0000}; // I-stall
        vecs[7]  = '{1, 1, 0, 0, 1, 32'h0000_0070, 8'b11111_111, 32'h0000_0070}; // br with resp: immediate
        vecs[8]  = '{1, 0, 0, 0, 1, 32'h0000_0080, 8'b00111_010, 32'h0000_0080}; // -> REDIR_WAIT
        vecs[9]  = '{1, 0, 0, 0, 1, 32'h0000_0099, 8'b00111_010, 32'h0000_0080}; // br ignored
        vecs[10] = '{1, 0, 0, 0, 0, 32'h0000_0000, 8'b00111_010, 32'h0000_0080};
        vecs[11] = '{1, 1, 0, 0, 0, 32'h0000_0000, 8'b11111_111, 32'h0000_0080}; // resp: redirect
        vecs[12] = '{0, 0, 0, 0, 0, 32'h0000_0004, 8'b11111_000, 32'h0000_0004}; // back in RUN
        vecs[13] = '{1, 0, 0, 0, 1, 32'h0000_00A0, 8'b00111_010, 32'h0000_00A0}; // -> REDIR_WAIT
        vecs[14] = '{1, 1, 1, 0, 0, 32'h0000_0000, 8'b00000_000, 32'h0000_00A0}; // resp under D-stall
        vecs[15] = '{1, 1, 0, 0, 0, 32'h0000_0000, 8'b11111_111, 32'h0000_00A0}; // deferred redirect
        vecs[16] = '{0, 0, 0, 0, 0, 32'h0000_0008, 8'b11111_000, 32'h0000_0008};

        // Reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", {24'h0, ctl}, 32'h0);
        check("reset_stall_cnt", stall_cycles, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].ir, vecs[i].irsp, vecs[i].dreq, vecs[i].drsp, vecs[i].br, vecs[i].tgt);
            #1;
            check($sformatf("vec%0d_ctl", i), {24'h0, ctl}, {24'h0, vecs[i].exp_ctl});
            check($sformatf("vec%0d_addr", i), pc_redirect_addr, vecs[i].exp_addr);
            if (!vecs[i].exp_ctl[7]) exp_stall++;
            if (vecs[i].exp_ctl[2])  exp_flush++;
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        check("table_stall_cnt", stall_cycles, 32'(exp_stall));
        check("table_flush_cnt", flush_count, 32'(exp_flush));
`else
        check("table_stall_cnt", stall_cycles, 32'h0);
        check("table_flush_cnt", flush_count, 32'h0);
`endif

        // Reset asserted while REDIR_WAIT is pending and a D-access is held
        drive(1, 0, 0, 0, 1, 32'h0000_00C0);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {24'h0, ctl}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0000_1234);
        rst_n = 1'b1;
        #1;
        check("post_rst_ctl", {24'h0, ctl}, 32'h0000_00F8);
        check("post_rst_addr", pc_redirect_addr, 32'h0000_1234);
        check("post_rst_stall_cnt", stall_cycles, 32'h0);
        check("post_rst_flush_cnt", flush_count, 32'h0);

        // Three D-stall cycles, then completion
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 0, 32'h0);
            #1;
            check($sformatf("dstall%0d_ctl", c), {24'h0, ctl}, 32'h0);
        end
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 32'h0);
        #1;
        check("dstall_done_ctl", {24'h0, ctl}, 32'h0000_00F8);
`ifdef HAZARD_PERF_CNT_EN
        check("dstall_cnt", stall_cycles, 32'd3);
`else
        check("dstall_cnt", stall_cycles, 32'd0);
`endif

`ifdef HAZARD_PERF_CNT_EN
        // Saturation
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 32'h0);
        force dut.stall_q = 32'hFFFF_FFFE;
        #1 release dut.stall_q;
        repeat (3) @(negedge clk);
        #1;
        check("stall_cnt_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
